alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu.sv | 24 ++
 rtl/alu_issue_queue.sv | 93 +++++++++
 tb/tb_alu_issue_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUOp encodings shared by the decoder, the ALU and the issue queue.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SRL = 3'b100,
      ALU_SRA = 3'b101
   } alu_op_e;

   localparam int DATA_W = 32;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU; codes 110/111 alias the arithmetic right shift.
module alu
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        alu_op,
   output logic [DATA_W-1:0] c
);

   // Shifts take the full 32-bit b, so amounts of 32 or more saturate to zero / sign fill.
   always_comb begin
      c = '0;
      case (alu_op)
         ALU_ADD: c = a + b;
         ALU_SUB: c = a - b;
         ALU_AND: c = a & b;
         ALU_OR:  c = a | b;
         ALU_SRL: c = a >> b;
         default: c = $unsigned($signed(a) >>> b);
      endcase
   end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - circular operand FIFO feeding one ALU into a registered result stage.
module alu_issue_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAGW  = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_a,
   input  logic [DATA_W-1:0]          in_b,
   input  logic [2:0]                 in_op,
   input  logic [TAGW-1:0]            in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_c,
   output logic [TAGW-1:0]            out_tag,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem_a   [DEPTH];
   logic [DATA_W-1:0] mem_b   [DEPTH];
   logic [2:0]        mem_op  [DEPTH];
   logic [TAGW-1:0]   mem_tag [DEPTH];

   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     occ;
   logic [DATA_W-1:0] alu_c;
   logic              full, empty, push, issue;

   assign full     = (occ == CW'(DEPTH));
   assign empty    = (occ == '0);
   assign in_ready = !full;
   assign count    = occ;
   assign push     = in_valid && !full && !flush;
   assign issue    = !empty && (!out_valid || out_ready) && !flush;

   alu u_alu (
      .a      (mem_a[rd_ptr]),
      .b      (mem_b[rd_ptr]),
      .alu_op (mem_op[rd_ptr]),
      .c      (alu_c)
   );

   // Payload storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_a;
         mem_b[wr_ptr]   <= in_b;
         mem_op[wr_ptr]  <= in_op;
         mem_tag[wr_ptr] <= in_tag;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         out_valid <= 1'b0;
         out_c     <= '0;
         out_tag   <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (issue)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !issue)
            occ <= occ + 1'b1;
         else if (issue && !push)
            occ <= occ - 1'b1;
         if (issue) begin
            out_c     <= alu_c;
            out_tag   <= mem_tag[rd_ptr];
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue.
module tb_alu_issue_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic [2:0]  in_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_c;
   logic [4:0]  out_tag;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] c;
      logic [4:0]  tag;
   } exp_t;
   exp_t sb[$];

   alu_issue_queue #(.DEPTH(4), .TAGW(5)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_tag   (out_tag),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [2:0] op);
      logic [31:0] r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a + ~b + 32'd1;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: begin
            if (b >= 32) r = 32'd0;
            else begin
               r = a;
               for (int i = 0; i < 32; i++) if (i < b) r = {1'b0, r[31:1]};
            end
         end
         default: begin
            if (b >= 32) r = {32{a[31]}};
            else begin
               r = a;
               for (int i = 0; i < 32; i++) if (i < b) r = {r[31], r[31:1]};
            end
         end
      endcase
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [4:0] tag);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
   endtask

   // Outputs are sampled on the falling edge, where the next rising edge's handshakes are settled.
   always @(negedge clk) begin
      if (!reset_n || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_result: observed=%h expected=none", out_c);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("result_c", out_c, e.c);
               check("result_tag", 32'(out_tag), 32'(e.tag));
            end
         end
         if (in_valid && in_ready)
            sb.push_back('{c: model(in_a, in_b, in_op), tag: in_tag});
      end
   end

   initial begin
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
      tick(); tick();
      check("reset_count", 32'(count), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_c", out_c, 32'h0);
      check("reset_out_tag", 32'(out_tag), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;
      tick();

      // Single op: two-edge latency.
      out_ready = 1'b1;
      drive(32'd5, 32'd3, 3'b001, 5'd7);
      tick();
      in_valid = 1'b0;
      check("lat_edge1_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_edge2_valid", 32'(out_valid), 32'd1);
      check("lat_out_c", out_c, 32'd2);
      check("lat_out_tag", 32'(out_tag), 32'd7);
      tick();
      check("lat_consumed", 32'(out_valid), 32'd0);

      // Back-to-back ops covering every encoding and shift boundaries.
      drive(32'hFFFF_FFFF, 32'd1, 3'b000, 5'd1);  tick();
      drive(32'd0, 32'd1, 3'b001, 5'd2);          tick();
      drive(32'h8000_0000, 32'd4, 3'b101, 5'd3);  tick();
      drive(32'h8000_0000, 32'd4, 3'b100, 5'd4);  tick();
      drive(32'h8000_0000, 32'd40, 3'b101, 5'd5); tick();
      drive(32'hF0F0_1234, 32'h0FF0_FF00, 3'b010, 5'd6); tick();
      drive(32'hF0F0_1234, 32'h0FF0_FF00, 3'b011, 5'd8); tick();
      drive(32'h8000_0001, 32'd31, 3'b110, 5'd9); tick();
      drive(32'h7000_0000, 32'd32, 3'b111, 5'd10); tick();
      drive(32'hDEAD_BEEF, 32'd32, 3'b100, 5'd11); tick();
      in_valid = 1'b0;
      repeat (4) tick();
      check("stream_count", 32'(count), 32'd0);
      check("stream_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure: fill to full, stall a sixth, then drain.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(32'd100 + i, 32'd10 * i, 3'b000, 5'(12 + i));
         tick();
      end
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      drive(32'd500, 32'd5, 3'b001, 5'd20);
      tick(); tick();
      check("stall_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      tick();
      check("full_pop_only_count", 32'(count), 32'd3);
      tick();
      check("push_pop_count", 32'(count), 32'd3);
      in_valid = 1'b0;
      repeat (8) tick();
      check("drain_count", 32'(count), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_sb_empty", 32'(sb.size()), 32'd0);

      // Flush with held result and three queued entries.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(32'd7 * i, 32'd1, 3'b011, 5'(i));
         tick();
      end
      check("pre_flush_count", 32'(count), 32'd3);
      check("pre_flush_valid", 32'(out_valid), 32'd1);
      drive(32'd9, 32'd9, 3'b000, 5'd30);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      tick();
      check("post_flush_count", 32'(count), 32'd0);
      check("post_flush_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-cycle with a full queue.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(32'hA000_0000 + i, 32'd2, 3'b101, 5'(i + 1));
         tick();
      end
      in_valid = 1'b0;
      check("arst_pre_count", 32'(count), 32'd4);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_c", out_c, 32'h0);
      check("arst_out_tag", 32'(out_tag), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      tick();
      reset_n = 1'b1;
      tick();

      out_ready = 1'b1;
      drive(32'h1234_5678, 32'h1111_1111, 3'b001, 5'd31);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("final_sb_empty", 32'(sb.size()), 32'd0);
      check("final_count", 32'(count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
